// File: rtl/param_router.sv
// N_IN x N_OUT word router: per-input FIFOs with drop filtering, per-output
// round-robin arbitration into a single registered output slot.
module param_router #(
  parameter int N_IN      = 17,
  parameter int N_OUT     = 3,
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 4,
  parameter int PARITY_EN = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_IN*DATA_W-1:0]  in_data,
  input  logic [N_IN-1:0]         in_valid,
  output logic [N_IN-1:0]         in_ready,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic [N_OUT-1:0]        out_valid,
  input  logic [N_OUT-1:0]        out_ready,
  output logic [N_IN-1:0]         fifo_full,
  output logic [15:0]             drop_count
);

  localparam int DEST_W = $clog2(N_OUT);
  localparam int DW1    = DEST_W + 1;
  localparam int IW     = $clog2(N_IN);
  localparam int PW     = $clog2(DEPTH);
  localparam int PW1    = PW + 1;
  localparam int CW     = $clog2(N_IN + 1);

  localparam logic [DEST_W:0] N_OUT_L = DW1'(N_OUT);
  localparam logic [PW:0]     DEPTH_L = PW1'(DEPTH);

  logic [DATA_W-1:0] mem    [N_IN][DEPTH];
  logic [PW-1:0]     rd_ptr [N_IN];
  logic [PW-1:0]     wr_ptr [N_IN];
  logic [PW:0]       count  [N_IN];

  logic [N_IN-1:0]   push;
  logic [N_IN-1:0]   pop;
  logic [N_IN-1:0]   drop;
  logic [N_IN-1:0]   empty;
  logic [DATA_W-1:0] head      [N_IN];
  logic [DEST_W-1:0] head_dest [N_IN];

  logic [N_IN-1:0]   req        [N_OUT];
  logic [N_OUT-1:0]  gnt_valid;
  logic [N_OUT-1:0]  load_en;
  logic [IW-1:0]     gnt_idx    [N_OUT];
  logic [IW-1:0]     last_grant [N_OUT];

  logic [CW-1:0]     n_drop;
  logic [16:0]       drop_sum;

  // Input side: occupancy flags, accept/drop classification, FIFO heads.
  always_comb begin
    logic [DATA_W-1:0] word;
    logic              bad;
    logic              acc;
    push  = '0;
    drop  = '0;
    empty = '0;
    fifo_full = '0;
    in_ready  = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      word = in_data[i*DATA_W +: DATA_W];
      bad  = ({1'b0, word[DATA_W-1 -: DEST_W]} >= N_OUT_L) ||
             ((PARITY_EN != 0) && (^word));
      fifo_full[i] = (count[i] == DEPTH_L);
      in_ready[i]  = !fifo_full[i];
      empty[i]     = (count[i] == '0);
      acc          = in_valid[i] && in_ready[i];
      push[i]      = acc && !bad;
      drop[i]      = acc && bad;
      head[i]      = mem[i][rd_ptr[i]];
      head_dest[i] = head[i][DATA_W-1 -: DEST_W];
    end
  end

  always_comb begin
    n_drop = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      n_drop = n_drop + CW'(drop[i]);
    end
    drop_sum = {1'b0, drop_count} + 17'(n_drop);
  end

  // Round-robin search begins one past the last granted input, wrapping at N_IN.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    gnt_valid = '0;
    for (int unsigned o = 0; o < N_OUT; o++) begin
      gnt_idx[o] = '0;
      load_en[o] = !out_valid[o] || out_ready[o];
      for (int unsigned i = 0; i < N_IN; i++) begin
        req[o][i] = !empty[i] && (head_dest[i] == DEST_W'(o));
      end
      for (int unsigned k = 0; k < N_IN; k++) begin
        idx = 32'(last_grant[o]) + 32'd1 + k;
        if (idx >= N_IN) idx = idx - N_IN;
        if (!gnt_valid[o] && req[o][IW'(idx)]) begin
          gnt_valid[o] = 1'b1;
          gnt_idx[o]   = IW'(idx);
        end
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int unsigned o = 0; o < N_OUT; o++) begin
      if (load_en[o] && gnt_valid[o]) pop[gnt_idx[o]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= in_data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < N_IN; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_IN; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + 1'b1;
          2'b01:   count[i] <= count[i] - 1'b1;
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid  <= '0;
      out_data   <= '0;
      drop_count <= '0;
      for (int unsigned o = 0; o < N_OUT; o++) begin
        last_grant[o] <= IW'(N_IN - 1);
      end
    end else begin
      drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      for (int unsigned o = 0; o < N_OUT; o++) begin
        if (load_en[o]) begin
          out_valid[o] <= gnt_valid[o];
          if (gnt_valid[o]) begin
            out_data[o*DATA_W +: DATA_W] <= head[gnt_idx[o]];
            last_grant[o]                <= gnt_idx[o];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_param_router.sv
// Scoreboard bench for param_router: directed stimulus queues expected words
// per output; a negedge monitor checks every completed output transfer.
module tb_param_router;
  localparam int N_IN  = 17;
  localparam int N_OUT = 3;
  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic [N_IN*DW-1:0]   in_data;
  logic [N_IN-1:0]      in_valid;
  logic [N_IN-1:0]      in_ready;
  logic [N_OUT*DW-1:0]  out_data;
  logic [N_OUT-1:0]     out_valid;
  logic [N_OUT-1:0]     out_ready;
  logic [N_IN-1:0]      fifo_full;
  logic [15:0]          drop_count;

  int errors = 0;
  int checks = 0;

  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [15:0] q2[$];

  param_router #(
    .N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(DW), .DEPTH(DEPTH), .PARITY_EN(1)
  ) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_full(fifo_full), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int o, input logic [15:0] w);
    case (o)
      0: q0.push_back(w);
      1: q1.push_back(w);
      default: q2.push_back(w);
    endcase
  endtask

  task automatic get_exp(input int o, output logic have, output logic [15:0] w);
    have = 1'b0;
    w    = '0;
    case (o)
      0: if (q0.size() > 0) begin have = 1'b1; w = q0.pop_front(); end
      1: if (q1.size() > 0) begin have = 1'b1; w = q1.pop_front(); end
      default: if (q2.size() > 0) begin have = 1'b1; w = q2.pop_front(); end
    endcase
  endtask

  task automatic drive_word(input int p, input logic [15:0] w);
    in_valid[p]         = 1'b1;
    in_data[p*DW +: DW] = w;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Each transfer (valid && ready ahead of the next edge) is compared exactly once.
  always @(negedge clk) begin
    logic        have;
    logic [15:0] exp_w;
    if (reset) begin
      for (int o = 0; o < N_OUT; o++) begin
        if (out_valid[o] && out_ready[o]) begin
          get_exp(o, have, exp_w);
          checks++;
          if (!have) begin
            errors++;
            $display("FAIL unexpected_out%0d: got 0x%0h expected no word", o, out_data[o*DW +: DW]);
          end else if (out_data[o*DW +: DW] !== exp_w) begin
            errors++;
            $display("FAIL sb_out%0d: got 0x%0h expected 0x%0h", o, out_data[o*DW +: DW], exp_w);
          end
        end
      end
    end
  end

  logic [15:0] bp_words [6];
  logic        accepted;
  logic [N_OUT-1:0] seen_valid;

  initial begin
    bp_words = '{16'h8001, 16'h8002, 16'h8004, 16'h8008, 16'h8010, 16'h8020};
    in_valid  = '0;
    in_data   = '0;
    out_ready = 3'b111;
    reset     = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'h1FFFF);
    check("rst_fifo_full", 32'(fifo_full), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_drop_count", 32'(drop_count), 32'h0);
    reset = 1'b1;
    tick();
    check("post_rst_in_ready", 32'(in_ready), 32'h1FFFF);

    // Single word, uncontended latency
    drive_word(5, 16'h4001);
    push_exp(1, 16'h4001);
    tick();
    in_valid = '0;
    check("t1_not_yet", 32'(out_valid), 32'h0);
    tick();
    check("t1_valid", 32'(out_valid), 32'h2);
    check("t1_data", 32'(out_data[1*DW +: DW]), 32'h4001);
    tick();
    check("t1_one_cycle", 32'(out_valid), 32'h0);

    // Three-way contention on output 0
    drive_word(0, 16'h0000);
    drive_word(3, 16'h0003);
    drive_word(16, 16'h0011);
    push_exp(0, 16'h0000);
    push_exp(0, 16'h0003);
    push_exp(0, 16'h0011);
    tick();
    in_valid = '0;
    tick();
    check("t2_v0", 32'(out_valid[0]), 32'h1);
    check("t2_d0", 32'(out_data[0 +: DW]), 32'h0000);
    tick();
    check("t2_v1", 32'(out_valid[0]), 32'h1);
    check("t2_d1", 32'(out_data[0 +: DW]), 32'h0003);
    tick();
    check("t2_v2", 32'(out_valid[0]), 32'h1);
    check("t2_d2", 32'(out_data[0 +: DW]), 32'h0011);
    tick();
    check("t2_done", 32'(out_valid[0]), 32'h0);

    // Backpressure on output 2: slot plus DEPTH entries, then full
    out_ready = 3'b011;
    for (int k = 0; k < 6; k++) begin
      drive_word(2, bp_words[k]);
      push_exp(2, bp_words[k]);
      @(negedge clk);
      if (k < 5) begin
        check("t3_ready", 32'(in_ready[2]), 32'h1);
        tick();
      end else begin
        check("t3_refused", 32'(in_ready[2]), 32'h0);
        check("t3_full", 32'(fifo_full[2]), 32'h1);
      end
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      check("t3_hold_full", 32'(fifo_full[2]), 32'h1);
      check("t3_hold_valid", 32'(out_valid[2]), 32'h1);
      check("t3_hold_data", 32'(out_data[2*DW +: DW]), 32'h8001);
    end
    out_ready = 3'b111;
    accepted  = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (in_ready[2]) begin
        tick();
        in_valid = '0;
        accepted = 1'b1;
        break;
      end
    end
    in_valid = '0;
    check("t3_sixth_accepted", 32'(accepted), 32'h1);
    repeat (12) tick();
    check("t3_all_drained", 32'(q2.size()), 32'h0);

    // Two drops in one cycle: bad destination and odd parity
    drive_word(1, 16'hC003);
    drive_word(2, 16'h4003);
    tick();
    in_valid   = '0;
    seen_valid = '0;
    check("t4_drop_count", 32'(drop_count), 32'h2);
    repeat (3) begin
      tick();
      seen_valid = seen_valid | out_valid;
    end
    check("t4_no_output", 32'(seen_valid), 32'h0);

    // Saturation: 17 drops per cycle for 3855 cycles is exactly 65535
    reset = 1'b0;
    #2;
    check("t5_rst_drop", 32'(drop_count), 32'h0);
    reset = 1'b1;
    tick();
    in_data  = {N_IN{16'hC000}};
    in_valid = '1;
    for (int c = 1; c <= 3855; c++) begin
      tick();
      if (c == 1) check("t5_first", 32'(drop_count), 32'd17);
    end
    check("t5_at_max", 32'(drop_count), 32'hFFFF);
    in_valid = 17'h00007;
    tick();
    in_valid = '0;
    check("t5_saturated", 32'(drop_count), 32'hFFFF);

    // Mid-operation reset with all outputs presenting and words queued
    out_ready = 3'b000;
    drive_word(4, 16'h0005);
    drive_word(6, 16'h4001);
    drive_word(7, 16'h8001);
    drive_word(8, 16'h0003);
    tick();
    in_valid = '0;
    tick();
    check("t6_all_valid", 32'(out_valid), 32'h7);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("t6_rst_valid", 32'(out_valid), 32'h0);
    check("t6_rst_data", 32'(out_data), 32'h0);
    check("t6_rst_drop", 32'(drop_count), 32'h0);
    check("t6_rst_ready", 32'(in_ready), 32'h1FFFF);
    check("t6_rst_full", 32'(fifo_full), 32'h0);
    @(posedge clk);
    #1;
    reset      = 1'b1;
    out_ready  = 3'b111;
    seen_valid = '0;
    repeat (10) begin
      tick();
      seen_valid = seen_valid | out_valid;
    end
    check("t6_no_reappear", 32'(seen_valid), 32'h0);

    check("end_q0_empty", 32'(q0.size()), 32'h0);
    check("end_q1_empty", 32'(q1.size()), 32'h0);
    check("end_q2_empty", 32'(q2.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
